// File: rtl/dl_thermo_decoder.sv
// Thermometer-to-binary decoder for the carry-chain delay line: bubble filter,
// edge position, multi-transition flag and a saturating error counter.
`timescale 1ns/1ps

module dl_thermo_decoder #(
  parameter int LENGTH     = 16,
  parameter int ERR_W      = 16,
  parameter int BUBBLE_FIX = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LENGTH-1:0]              tap_word,
  input  logic                           sample_en,
  input  logic                           err_clr,
  output logic                           code_valid,
  output logic [$clog2(LENGTH+1)-1:0]    code,
  output logic                           edge_pol,
  output logic                           no_edge,
  output logic                           bubble,
  output logic                           multi,
  output logic [ERR_W-1:0]               err_cnt
);

  localparam int CODE_W = $clog2(LENGTH+1);

  logic [LENGTH-1:0] t0, t1, t1_next;
  logic [LENGTH+1:0] t0_ext;
  logic              v0, v1, bub1;
  logic [CODE_W-1:0] code_next, same_cnt;
  logic              found, multi_next, inc;

  // End taps are replicated so a single-tap run at either end survives the vote.
  assign t0_ext = {t0[LENGTH-1], t0, t0[0]};

  always_comb begin
    t1_next = t0;
    if (BUBBLE_FIX != 0) begin
      for (int i = 0; i < LENGTH; i++) begin
        t1_next[i] = (t0_ext[i] & t0_ext[i+1]) |
                     (t0_ext[i] & t0_ext[i+2]) |
                     (t0_ext[i+1] & t0_ext[i+2]);
      end
    end
  end

  always_comb begin
    code_next = CODE_W'(LENGTH);
    same_cnt  = '0;
    found     = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      if (t1[i] == t1[0]) begin
        same_cnt = same_cnt + CODE_W'(1);
      end else if (!found) begin
        found     = 1'b1;
        code_next = CODE_W'(i);
      end
    end
    // Any tap matching bit 0 beyond the first edge means a second transition.
    multi_next = (same_cnt != code_next);
  end

  assign inc = v1 & (bub1 | multi_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0         <= '0;
      v0         <= 1'b0;
      t1         <= '0;
      bub1       <= 1'b0;
      v1         <= 1'b0;
      code_valid <= 1'b0;
      code       <= '0;
      edge_pol   <= 1'b0;
      no_edge    <= 1'b0;
      bubble     <= 1'b0;
      multi      <= 1'b0;
      err_cnt    <= '0;
    end else begin
      v0 <= sample_en;
      if (sample_en) t0 <= tap_word;
      t1         <= t1_next;
      bub1       <= (t1_next != t0);
      v1         <= v0;
      code_valid <= v1;
      if (v1) begin
        code     <= code_next;
        edge_pol <= t1[0];
        no_edge  <= (code_next == CODE_W'(LENGTH));
        bubble   <= bub1;
        multi    <= multi_next;
      end
      if (err_clr) begin
        err_cnt <= inc ? ERR_W'(1) : '0;
      end else if (inc && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dl_thermo_decoder.sv
// Scoreboard bench for dl_thermo_decoder: directed corner cases then random
// tap words, checked against a tap-array reference model.
`timescale 1ns/1ps

module tb_dl_thermo_decoder;

  localparam int L = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [L-1:0]  tap_word;
  logic          sample_en;
  logic          err_clr;

  logic          code_valid, code_valid_b;
  logic [4:0]    code, code_b;
  logic          edge_pol, no_edge, bubble, multi;
  logic          edge_pol_b, no_edge_b, bubble_b, multi_b;
  logic [15:0]   err_cnt;
  logic [3:0]    err_cnt_b;

  typedef struct {
    int   code;
    logic pol;
    logic no_edge;
    logic bubble;
    logic multi;
    int   out_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mdl_a, mdl_b;
  logic        clr_last;

  dl_thermo_decoder #(.LENGTH(L), .ERR_W(16), .BUBBLE_FIX(1)) dut (
    .clk(clk), .rst(rst), .tap_word(tap_word), .sample_en(sample_en),
    .err_clr(err_clr), .code_valid(code_valid), .code(code),
    .edge_pol(edge_pol), .no_edge(no_edge), .bubble(bubble), .multi(multi),
    .err_cnt(err_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  dl_thermo_decoder #(.LENGTH(L), .ERR_W(4), .BUBBLE_FIX(1)) dut_b (
    .clk(clk), .rst(rst), .tap_word(tap_word), .sample_en(sample_en),
    .err_clr(err_clr), .code_valid(code_valid_b), .code(code_b),
    .edge_pol(edge_pol_b), .no_edge(no_edge_b), .bubble(bubble_b),
    .multi(multi_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [L-1:0] tap);
    exp_t e;
    logic f[L];
    int   votes, trans;
    e.bubble = 1'b0;
    for (int i = 0; i < L; i++) begin
      votes = int'(tap[(i == 0) ? 0 : i-1]) + int'(tap[i]) +
              int'(tap[(i == L-1) ? L-1 : i+1]);
      f[i] = (votes >= 2);
      if (f[i] != tap[i]) e.bubble = 1'b1;
    end
    e.pol  = f[0];
    e.code = L;
    for (int i = L-1; i > 0; i--) if (f[i] != f[0]) e.code = i;
    trans = 0;
    for (int i = 1; i < L; i++) if (f[i] != f[i-1]) trans++;
    e.multi   = (trans > 1);
    e.no_edge = (e.code == L);
    e.out_cyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [L-1:0] tap,
                               input logic clr);
    exp_t e;
    @(posedge clk); #1;
    sample_en = en;
    tap_word  = tap;
    err_clr   = clr;
    if (en) begin
      e = model(tap);
      e.out_cyc = cyc + 3;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulseReset(input int n);
    @(posedge clk); #1;
    sample_en = 1'b0;
    err_clr   = 1'b0;
    rst       = 1'b1;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [L-1:0] randomTap();
    int          pos;
    logic [L-1:0] w, mask;
    pos  = $urandom_range(0, L);
    mask = (pos == L) ? {L{1'b1}} : ((L'(1) << pos) - L'(1));
    w    = $urandom_range(0, 1) ? mask : ~mask;
    case ($urandom_range(0, 3))
      0, 1: ;
      2:    w[$urandom_range(0, L-1)] ^= 1'b1;
      default: w = L'($urandom);
    endcase
    return w;
  endfunction

  // Monitor: pops one expectation per strobe and tracks both error counters.
  always @(negedge clk) begin
    exp_t e;
    logic inc;
    if (rst) begin
      checkOutput("reset_valid", {31'd0, code_valid}, 32'd0);
      checkOutput("reset_err", {12'd0, err_cnt_b, err_cnt}, 32'd0);
      mdl_a    = 0;
      mdl_b    = 0;
      clr_last = 1'b0;
      last     = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    end else begin
      inc = 1'b0;
      if (code_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("latency", cyc, e.out_cyc);
          checkOutput("code", {27'd0, code}, e.code);
          checkOutput("flags", {28'd0, edge_pol, no_edge, bubble, multi},
                      {28'd0, e.pol, e.no_edge, e.bubble, e.multi});
          last = e;
          inc  = e.bubble | e.multi;
        end
      end else begin
        checkOutput("hold", {23'd0, code, edge_pol, no_edge, bubble, multi},
                    {23'd0, 5'(last.code), last.pol, last.no_edge, last.bubble, last.multi});
      end
      checkOutput("valid_b", {31'd0, code_valid_b}, {31'd0, code_valid});
      mdl_a = clr_last ? int'(inc) : ((mdl_a == 65535) ? mdl_a : mdl_a + int'(inc));
      mdl_b = clr_last ? int'(inc) : ((mdl_b == 15) ? mdl_b : mdl_b + int'(inc));
      if (code_valid || clr_last) begin
        checkOutput("err_cnt", {16'd0, err_cnt}, mdl_a);
        checkOutput("err_cnt_w4", {28'd0, err_cnt_b}, mdl_b);
      end
      clr_last = err_clr;
    end
  end

  initial begin
    rst       = 1'b1;
    sample_en = 1'b0;
    tap_word  = '0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(1'b1, 16'h00FF, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h00F7, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h0001, 1'b0);
    applyStimulus(1'b1, 16'h0003, 1'b0);
    applyStimulus(1'b1, 16'h0007, 1'b0);
    applyStimulus(1'b1, 16'h000F, 1'b0);
    applyStimulus(1'b1, 16'h8000, 1'b0);
    applyStimulus(1'b1, 16'h0F0F, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'h0F0F, 1'b0);
    repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0);

    // err_clr lands on the same edge as the erroneous sample's output.
    applyStimulus(1'b1, 16'h0F0F, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);

    applyStimulus(1'b1, 16'h00FF, 1'b0);
    applyStimulus(1'b1, 16'h0F0F, 1'b0);
    pulseReset(2);
    repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h003F, 1'b0);
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), randomTap(),
                    ($urandom_range(0, 19) == 0));
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) checkOutput("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
